// File: rtl/alu_control_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_control_mc_pkg
// Shared constants for the EX-stage ALU control block and its multi-cycle
// MUL/UDIV unit. Contents:
//   - ALU_* single-cycle function codes driven on alu_control
//   - OP_* alu_op instruction class codes
//   - state_e, the multi-cycle FSM state encoding
//   - is_mc_op(), true for the classes that start a multi-cycle operation
// -----------------------------------------------------------------------------
package alu_control_mc_pkg;

   typedef logic [2:0] alu_op_t;
   typedef logic [3:0] alu_fn_t;

   // ALU function codes. R-type decode produces {0, op[9], op[3], op[8]}, so
   // AND/OR/ADD/SUB sit where that mapping lands them.
   localparam alu_fn_t ALU_AND    = 4'b0000;
   localparam alu_fn_t ALU_OR     = 4'b0001;
   localparam alu_fn_t ALU_ADD    = 4'b0010;
   localparam alu_fn_t ALU_SUB    = 4'b0110;
   localparam alu_fn_t ALU_PASS_B = 4'b0111;
   localparam alu_fn_t ALU_LSL    = 4'b1000;
   localparam alu_fn_t ALU_LSR    = 4'b1001;

   // alu_op instruction classes; 11x is reserved.
   localparam alu_op_t OP_DTYPE  = 3'b000;
   localparam alu_op_t OP_BRANCH = 3'b001;
   localparam alu_op_t OP_SHIFT  = 3'b010;
   localparam alu_op_t OP_RTYPE  = 3'b011;
   localparam alu_op_t OP_MUL    = 3'b100;
   localparam alu_op_t OP_UDIV   = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   function automatic logic is_mc_op(input alu_op_t op);
      return (op == OP_MUL) || (op == OP_UDIV);
   endfunction

endpackage

// File: rtl/alu_control_mc_if.sv
// -----------------------------------------------------------------------------
// alu_control_mc_if
// EX-stage bundle between the pipeline (master) and alu_control_mc (slave).
//   master -> slave : valid_in, flush, alu_op, opcode, a, b
//   slave -> master : alu_control, stall, mc_result, mc_valid, div_by_zero
// DATA_W must match the DATA_W of the attached alu_control_mc.
// -----------------------------------------------------------------------------
interface alu_control_mc_if
   import alu_control_mc_pkg::*;
#(
   parameter int DATA_W = 64
);
   logic              valid_in;
   logic              flush;
   alu_op_t           alu_op;
   logic [10:0]       opcode;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   alu_fn_t           alu_control;
   logic              stall;
   logic [DATA_W-1:0] mc_result;
   logic              mc_valid;
   logic              div_by_zero;

   modport master (
      output valid_in, flush, alu_op, opcode, a, b,
      input  alu_control, stall, mc_result, mc_valid, div_by_zero
   );

   modport slave (
      input  valid_in, flush, alu_op, opcode, a, b,
      output alu_control, stall, mc_result, mc_valid, div_by_zero
   );
endinterface

// File: rtl/alu_control_mc_muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative unsigned datapath: shift-add multiply (low DATA_W bits of a*b) or
// restoring divide (floor(a/b)), one bit per step.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a, b and the operation kind
//   is_div     : operation kind sampled with start (1 = divide)
//   a, b       : operands sampled with start
//   step       : perform one iteration this cycle
//   result     : value the operation holds after the current step completes,
//                so the final step's result can be captured on the same edge
// -----------------------------------------------------------------------------
module muldiv_iter
   import alu_control_mc_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              step,
   output logic [DATA_W-1:0] result
);

   // MUL: acc = partial product, opa = multiplicand (<<), opb = multiplier (>>)
   // DIV: acc = remainder, opa = dividend shifting out / quotient shifting in,
   //      opb = divisor
   logic              is_div_q, is_div_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   rem_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_div_q <= 1'b0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
      end else begin
         is_div_q <= is_div_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
      end
   end

   always_comb begin
      is_div_d = is_div_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      rem_sh   = {acc_q, opa_q[DATA_W-1]};
      // Remainder stays below the divisor, so rem_sh < 2*b and the top bit of
      // the difference is a clean borrow flag.
      rem_sub  = rem_sh - {1'b0, opb_q};
      if (start) begin
         is_div_d = is_div;
         acc_d    = '0;
         opa_d    = a;
         opb_d    = b;
      end else if (step) begin
         if (is_div_q) begin
            if (rem_sub[DATA_W]) begin
               acc_d = rem_sh[DATA_W-1:0];
               opa_d = {opa_q[DATA_W-2:0], 1'b0};
            end else begin
               acc_d = rem_sub[DATA_W-1:0];
               opa_d = {opa_q[DATA_W-2:0], 1'b1};
            end
         end else begin
            if (opb_q[0]) begin
               acc_d = acc_q + opa_q;
            end
            opa_d = {opa_q[DATA_W-2:0], 1'b0};
            opb_d = {1'b0, opb_q[DATA_W-1:1]};
         end
      end
   end

   assign result = is_div_q ? opa_d : acc_d;

endmodule

// File: rtl/alu_control_mc.sv
// -----------------------------------------------------------------------------
// alu_control_mc
// EX-stage ALU control: combinational ALU function decode plus an FSM that
// runs multi-cycle unsigned MUL / UDIV through muldiv_iter and stalls the
// pipeline meanwhile.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus (slave): valid_in, flush, alu_op, opcode, a, b in;
//                alu_control, stall, mc_result, mc_valid, div_by_zero out
// Parameters: DATA_W (8..64, even), ZERO_DIV_Q (quotient for b == 0).
// -----------------------------------------------------------------------------
module alu_control_mc
   import alu_control_mc_pkg::*;
#(
   parameter int                DATA_W     = 64,
   parameter logic [DATA_W-1:0] ZERO_DIV_Q = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_control_mc_if.slave bus
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mc_result_q, mc_result_d;
   logic              dbz_q, dbz_d;

   logic              req_mc;
   logic              is_div_op;
   logic              b_zero;
   logic              start;
   logic              step;
   logic [DATA_W-1:0] iter_result;

   assign req_mc    = bus.valid_in && is_mc_op(bus.alu_op);
   assign is_div_op = (bus.alu_op == OP_UDIV);
   assign b_zero    = (bus.b == '0);
   // Divide-by-zero skips the datapath entirely and goes straight to DONE.
   assign start     = (state_q == ST_IDLE) && !bus.flush && req_mc && !(is_div_op && b_zero);
   assign step      = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !bus.flush;

   muldiv_iter #(
      .DATA_W (DATA_W)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .is_div (is_div_op),
      .a      (bus.a),
      .b      (bus.b),
      .step   (step),
      .result (iter_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mc_result_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mc_result_q <= mc_result_d;
         dbz_q       <= dbz_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mc_result_d = mc_result_q;
      dbz_d       = 1'b0;
      if (bus.flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_mc) begin
                  if (is_div_op && b_zero) begin
                     state_d     = ST_DONE;
                     mc_result_d = ZERO_DIV_Q;
                     dbz_d       = 1'b1;
                  end else begin
                     state_d = is_div_op ? ST_DIV : ST_MUL;
                     cnt_d   = CNT_LOAD;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               cnt_d = cnt_q - CNT_ONE;
               // Counter hits zero on this edge: the last step's result is
               // captured together with the move to DONE.
               if (cnt_q == CNT_ONE) begin
                  state_d     = ST_DONE;
                  mc_result_d = iter_result;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      case (bus.alu_op)
         OP_DTYPE:  bus.alu_control = ALU_ADD;
         OP_BRANCH: bus.alu_control = ALU_PASS_B;
         OP_SHIFT:  bus.alu_control = bus.opcode[0] ? ALU_LSL : ALU_LSR;
         OP_RTYPE:  bus.alu_control = {1'b0, bus.opcode[9], bus.opcode[3], bus.opcode[8]};
         default:   bus.alu_control = ALU_ADD;
      endcase
      // Gated by rst_n so stall is low for the whole reset interval.
      bus.stall    = rst_n && (((state_q == ST_IDLE) && req_mc) ||
                               (state_q == ST_MUL) || (state_q == ST_DIV));
      bus.mc_valid = (state_q == ST_DONE);
   end

   assign bus.mc_result   = mc_result_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/alu_control_mc.md
ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width in bits; legal values 8..64, even.
REQ-002 Parameter ZERO_DIV_Q, default 0, quotient returned on divide-by-zero.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_in  input  1  the instruction in EX is valid this cycle.
REQ-006 flush  input  1  synchronous abort of any multi-cycle operation.
REQ-007 alu_op  input  3  class: 000 D-type, 001 branch, 010 shift, 011 R-type, 100 MUL, 101 UDIV, 11x reserved.
REQ-008 opcode  input  11  instruction opcode field.
REQ-009 a, b  input  DATA_W  operands, used only for MUL/UDIV.
REQ-010 alu_control  output  4  single-cycle ALU function code.
REQ-011 stall  output  1  holds the pipeline while a multi-cycle operation is active.
REQ-012 mc_result  output  DATA_W  MUL/UDIV result.
REQ-013 mc_valid  output  1  one-cycle strobe: mc_result is valid.
REQ-014 div_by_zero  output  1  qualifies mc_valid for a UDIV with b==0.

Function
REQ-015 alu_control SHALL be combinational: 000 -> ALU_ADD; 001 -> ALU_PASS_B; 010 -> ALU_LSR if opcode[0]==0, else ALU_LSL; 011 -> {0, opcode[9], opcode[3], opcode[8]}; 100/101/11x -> ALU_ADD.
REQ-016 FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-017 In IDLE, valid_in && alu_op==100 SHALL latch a and b, load the iteration counter with DATA_W and go to MUL at the next edge (the accept edge E0).
REQ-018 alu_op==101 with b!=0 SHALL do the same, going to DIV.
REQ-019 alu_op==101 with b==0 SHALL go straight to DONE at E0, with mc_result=ZERO_DIV_Q and div_by_zero=1.
REQ-020 MUL SHALL use unsigned shift-add, one bit per cycle; mc_result SHALL be the low DATA_W bits of a*b.
REQ-021 DIV SHALL use restoring division, one quotient bit per cycle; mc_result SHALL be floor(a/b) unsigned.
REQ-022 The counter SHALL be clog2(DATA_W+1) bits wide and decrement once per edge in MUL/DIV; at the edge where it reaches 0 the FSM SHALL enter DONE, i.e. edge E0+DATA_W.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-024 mc_valid SHALL equal (state==DONE); div_by_zero SHALL be registered and meaningful only while mc_valid is high.
REQ-025 mc_result SHALL hold its value from DONE until the next DONE.
REQ-026 stall SHALL be (IDLE && valid_in && alu_op in {100,101}) || MUL || DIV; stall SHALL be low in DONE so the pipeline consumes the result.
REQ-027 valid_in SHALL be ignored outside IDLE; no operation is queued.
REQ-028 A new multi-cycle op presented in the DONE cycle SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-029 flush SHALL take priority over every transition: the FSM goes to IDLE at the next edge with no mc_valid, and flush in IDLE SHALL block acceptance that cycle.
REQ-030 Reserved alu_op values SHALL NOT start an operation.

Reset
REQ-031 While rst_n==0: state=IDLE, counter=0, mc_result=0, mc_valid=0, div_by_zero=0, stall=0, and the operand and working registers are cleared.
REQ-032 Reset mid-operation SHALL discard the operation with no mc_valid after release.
REQ-033 Release SHALL be synchronised by the clock; the first accept is possible on the first edge after release.

Structure
REQ-034 The ALU_* function codes, the alu_op class codes and the FSM state encoding SHALL live in the shared constants package/header.
REQ-035 The shift-add/restoring datapath SHALL be one sub-module, muldiv_iter (start, is_div, a, b, step, result); the FSM and decode stay in alu_control_mc.

Verification
REQ-036 alu_op=011, opcode=10001011000 (ADD) -> alu_control=0010 combinationally, with stall=0 and no FSM activity.
REQ-037 DATA_W=64, MUL a=7, b=9 -> stall high 65 cycles starting at the accept cycle; mc_valid at E0+64 for one cycle; mc_result=63.
REQ-038 DATA_W=8, UDIV a=200, b=7 -> mc_result=28, div_by_zero=0, latency 8 edges; DATA_W=8, MUL 255*255 -> mc_result=0x01.
REQ-039 UDIV a=5, b=0 -> DONE at E0, mc_valid=1, div_by_zero=1, mc_result=0.
REQ-040 MUL started, flush asserted at E0+10 -> IDLE next edge, and no mc_valid within 100 cycles; rst_n pulsed low mid-DIV -> all outputs 0 immediately.
REQ-041 Back-to-back MUL held on valid_in across DONE -> second accept in the IDLE cycle after DONE, and its result is correct.
